// File: rtl/pe_status_cfg_writer_if.sv
// Valid/ready write channel from the configuration initiator to the PE config network.
interface pe_status_cfg_writer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned PE_W = 6;

  logic              wr_valid;
  logic              wr_ready;
  logic [PE_W-1:0]   wr_pe_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_pe_idx,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_pe_idx,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/pe_status_cfg_writer.sv
// Boot-time initiator that programs layer count and packed activation counts
// into the status registers of every PE over a valid/ready write channel.
module pe_status_cfg_writer #(
  parameter int unsigned NUM_PE = 64,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            cfg_layer_no,
  input  logic [47:0]           cfg_act_no,
  pe_status_cfg_writer_if.master wr,
  output logic                  busy,
  output logic                  done
);
  localparam int unsigned PE_W   = 6;
  localparam int unsigned L_W    = 3;
  localparam int unsigned ACT_W  = 48;
  localparam int unsigned WORD_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [L_W-1:0]     layer_q, layer_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic [PE_W-1:0]    pe_q, pe_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               valid_q, valid_d;
  logic               busy_d, done_d;
  logic [PE_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               hs;
  logic               last_word;
  logic               last_pe;

  // Word 0 carries the layer count; word j carries act[2j-1]:act[2j-2].
  function automatic logic [DATA_W-1:0] word_data(input logic [L_W-1:0] layer,
                                                  input logic [ACT_W-1:0] act,
                                                  input logic [WORD_W-1:0] word);
    logic [11:0] pair;
    case (word)
      3'd1:    pair = act[11:0];
      3'd2:    pair = act[23:12];
      3'd3:    pair = act[35:24];
      default: pair = act[47:36];
    endcase
    if (word == 3'd0) return DATA_W'({13'b0, layer});
    return DATA_W'({2'b00, pair[11:6], 2'b00, pair[5:0]});
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [WORD_W-1:0] word);
    return ADDR_W'({word, 1'b0});
  endfunction

  assign hs        = valid_q && wr.wr_ready;
  assign last_word = (word_q == ({1'b0, layer_q[2:1]} + 3'd1));
  assign last_pe   = (pe_q == PE_W'(NUM_PE - 1));

  assign wr.wr_valid  = valid_q;
  assign wr.wr_pe_idx = idx_q;
  assign wr.wr_addr   = addr_q;
  assign wr.wr_data   = data_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      act_q   <= '0;
      pe_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      act_q   <= act_d;
      pe_q    <= pe_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next state and next registered outputs; payload only changes on a handshake.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    act_d   = act_q;
    pe_d    = pe_q;
    word_d  = word_q;
    valid_d = valid_q;
    busy_d  = busy;
    done_d  = 1'b0;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          layer_d = cfg_layer_no;
          act_d   = cfg_act_no;
          pe_d    = '0;
          word_d  = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          idx_d   = '0;
          addr_d  = '0;
          data_d  = word_data(cfg_layer_no, cfg_act_no, 3'd0);
        end
      end

      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (hs) begin
          if (last_word && last_pe) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (last_word) begin
            pe_d   = pe_q + 6'd1;
            word_d = '0;
            idx_d  = pe_q + 6'd1;
            addr_d = '0;
            data_d = word_data(layer_q, act_q, 3'd0);
          end else begin
            word_d = word_q + 3'd1;
            addr_d = word_addr(word_q + 3'd1);
            data_d = word_data(layer_q, act_q, word_q + 3'd1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_pe_status_cfg_writer.sv
// Randomized self-checking bench: two writers (2 PEs and 1 PE) against a queue-based model.
module tb_pe_status_cfg_writer;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;

  typedef logic [25:0] word_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [2:0]  cfg_layer_no;
  logic [47:0] cfg_act_no;
  logic        wr_ready;
  logic        sel1;
  logic        start1, start2;
  logic        busy1, busy2, done1, done2;

  int checks   = 0;
  int failures = 0;

  word_t exp_q[$];
  word_t got_q[$];
  int    viol;
  int    done_at;
  int    last_hs;
  bit    timed_out;

  pe_status_cfg_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if2 ();
  pe_status_cfg_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();

  assign start2 = start & ~sel1;
  assign start1 = start & sel1;
  assign if2.wr_ready = wr_ready;
  assign if1.wr_ready = wr_ready;

  pe_status_cfg_writer #(.NUM_PE(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort),
    .cfg_layer_no(cfg_layer_no), .cfg_act_no(cfg_act_no),
    .wr(if2), .busy(busy2), .done(done2)
  );

  pe_status_cfg_writer #(.NUM_PE(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .cfg_layer_no(cfg_layer_no), .cfg_act_no(cfg_act_no),
    .wr(if1), .busy(busy1), .done(done1)
  );

  logic  o_valid, o_busy, o_done;
  word_t o_word;
  assign o_valid = sel1 ? if1.wr_valid : if2.wr_valid;
  assign o_busy  = sel1 ? busy1 : busy2;
  assign o_done  = sel1 ? done1 : done2;
  assign o_word  = sel1 ? {if1.wr_pe_idx, if1.wr_addr, if1.wr_data}
                        : {if2.wr_pe_idx, if2.wr_addr, if2.wr_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected word list straight from the register map: per PE, layer word then pairs.
  function automatic void build_model(input int num_pe, input int layer, input logic [47:0] act);
    int npair;
    int lo, hi;
    logic [47:0] t;
    exp_q.delete();
    npair = layer / 2 + 1;
    for (int p = 0; p < num_pe; p++) begin
      exp_q.push_back({6'(p), 4'd0, 16'(layer)});
      for (int j = 1; j <= npair; j++) begin
        t  = act >> (12 * j - 12);
        lo = int'(t & 48'h3f);
        t  = act >> (12 * j - 6);
        hi = int'(t & 48'h3f);
        exp_q.push_back({6'(p), 4'(2 * j), 16'(hi * 256 + lo)});
      end
    end
  endfunction

  task automatic kick(input bit s1, input logic [2:0] layer, input logic [47:0] act);
    sel1         = s1;
    cfg_layer_no = layer;
    cfg_act_no   = act;
    wr_ready     = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Drives wr_ready (mode 0: always 1, mode 1: random), optional 4-cycle stall, records handshakes.
  task automatic collect(input int mode, input int stall_word, input bit churn, input int max_cyc);
    word_t prev;
    bit    prev_stall;
    bit    r;
    int    stall_left;
    got_q.delete();
    viol = 0; done_at = -1; last_hs = -1; timed_out = 1'b1;
    prev_stall = 1'b0; stall_left = 4; prev = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (prev_stall && (!o_valid || o_word !== prev)) viol++;
      if (o_valid && !o_busy) viol++;
      if (o_done) begin
        done_at = cyc;
        timed_out = 1'b0;
        break;
      end
      r = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (stall_word >= 0 && got_q.size() == stall_word && o_valid && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end
      wr_ready = r;
      if (churn) begin
        start        = 1'b1;
        cfg_layer_no = 3'($urandom);
        cfg_act_no   = {16'($urandom), $urandom};
      end
      if (o_valid && r) begin
        got_q.push_back(o_word);
        last_hs = cyc;
      end
      prev_stall = o_valid && !r;
      prev       = o_word;
      @(negedge clk);
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; sel1 = 1'b0;
    cfg_layer_no = '0; cfg_act_no = '0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if2.wr_valid, busy2, done2} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl2 got %b exp 000", {if2.wr_valid, busy2, done2});
    end
    checks++;
    if ({if2.wr_pe_idx, if2.wr_addr, if2.wr_data} !== 26'd0) begin
      failures++; $display("FAIL reset_payload2 got %h exp 0", {if2.wr_pe_idx, if2.wr_addr, if2.wr_data});
    end
    checks++;
    if ({if1.wr_valid, busy1, done1} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl1 got %b exp 000", {if1.wr_valid, busy1, done1});
    end
    checks++;
    if ({if1.wr_pe_idx, if1.wr_addr, if1.wr_data} !== 26'd0) begin
      failures++; $display("FAIL reset_payload1 got %h exp 0", {if1.wr_pe_idx, if1.wr_addr, if1.wr_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [47:0] act;
    act = {24'($urandom), 6'd12, 6'd9, 6'd40, 6'd5};
    build_model(2, 3, act);
    kick(1'b0, 3'd3, act);
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL basic_latency valid=%b busy=%b exp 1 1", o_valid, o_busy);
    end
    collect(0, -1, 1'b0, 100);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count got %0d exp %0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL basic_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() > 2 && got_q[1][15:0] !== 16'h2805) begin
      failures++; $display("FAIL basic_pair0 got %h exp 2805", got_q[1][15:0]);
    end
    checks++;
    if (done_at != last_hs + 1) begin
      failures++; $display("FAIL basic_done_timing got %0d exp %0d", done_at, last_hs + 1);
    end
    @(negedge clk);
    checks++;
    if ({o_valid, o_busy, o_done} !== 3'b000) begin
      failures++; $display("FAIL basic_after_done got %b exp 000", {o_valid, o_busy, o_done});
    end
  endtask

  task automatic test_l0_single_pe();
    logic [47:0] act;
    act = {42'({$urandom, $urandom}), 6'd63};
    build_model(1, 0, act);
    kick(1'b1, 3'd0, act);
    collect(0, -1, 1'b0, 100);
    checks++;
    if (timed_out || got_q.size() != 2) begin
      failures++; $display("FAIL l0_count got %0d exp 2 timeout=%0d", got_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL l0_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_l7_single_pe();
    logic [47:0] act;
    for (int k = 0; k < 8; k++) act[6*k +: 6] = 6'(k + 1);
    build_model(1, 7, act);
    kick(1'b1, 3'd7, act);
    collect(0, -1, 1'b0, 100);
    checks++;
    if (timed_out || got_q.size() != 5) begin
      failures++; $display("FAIL l7_count got %0d exp 5 timeout=%0d", got_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL l7_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() == 5 && got_q[4][19:0] !== {4'd8, 16'h0807}) begin
      failures++; $display("FAIL l7_last got %h exp 80807", got_q[4][19:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random_ready();
    logic [47:0] act;
    logic [2:0]  layer;
    bit          s1;
    for (int it = 0; it < 4; it++) begin
      layer = 3'($urandom);
      act   = {16'($urandom), $urandom};
      s1    = 1'($urandom);
      build_model(s1 ? 1 : 2, int'(layer), act);
      kick(s1, layer, act);
      collect(1, $urandom_range(0, exp_q.size() - 1), 1'b0, 400);
      checks++;
      if (timed_out || got_q.size() != exp_q.size() || viol != 0) begin
        failures++;
        $display("FAIL rand%0d_count got %0d exp %0d viol=%0d timeout=%0d",
                 it, got_q.size(), exp_q.size(), viol, timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_word%0d got %h exp %h", it, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_at != last_hs + 1) begin
        failures++; $display("FAIL rand%0d_done_timing got %0d exp %0d", it, done_at, last_hs + 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [47:0] act;
    int          dones;
    act = {16'($urandom), $urandom};
    build_model(2, 4, act);
    kick(1'b0, 3'd4, act);
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    wr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_word !== exp_q[2]) begin
      failures++; $display("FAIL abort_third_word got %b/%h exp 1/%h", o_valid, o_word, exp_q[2]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({o_valid, o_busy, o_done} !== 3'b000) begin
      failures++; $display("FAIL abort_stop got %b exp 000", {o_valid, o_busy, o_done});
    end
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done || o_valid) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL abort_quiet got %0d exp 0", dones);
    end
    // start and abort together in IDLE: start wins and the run restarts at pe0/addr0
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_word !== exp_q[0]) begin
      failures++; $display("FAIL abort_restart got %b/%h exp 1/%h", o_valid, o_word, exp_q[0]);
    end
    collect(0, -1, 1'b0, 100);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL abort_rerun_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL abort_rerun_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_busy_churn_and_rst();
    logic [47:0] act;
    int          bad;
    act = {16'($urandom), $urandom};
    build_model(2, 5, act);
    kick(1'b0, 3'd5, act);
    collect(1, -1, 1'b1, 400);
    checks++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL churn_count got %0d exp %0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL churn_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    // start still high while done was asserted: it must be ignored
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({o_valid, o_busy, o_done} !== 3'b000) begin
      failures++; $display("FAIL churn_done_start got %b exp 000", {o_valid, o_busy, o_done});
    end
    kick(1'b0, 3'd6, act);
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_busy, o_done, o_word} !== 29'd0) begin
      failures++; $display("FAIL rst_midrun got %h exp 0", {o_valid, o_busy, o_done, o_word});
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_done || o_valid || o_busy) bad++;
    end
    wr_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rst_no_done got %0d exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_l0_single_pe();
    test_l7_single_pe();
    test_random_ready();
    test_abort();
    test_busy_churn_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
